// File: rtl/digits_pkg.sv
// Shared types and constant helpers for the serial binary-to-BCD converter.
package digits_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Decimal digits needed to show the largest WIDTH-bit unsigned value.
    function automatic int dec_digits(input int width);
        longint unsigned v;
        int d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_adj3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/digits_serial.sv
// Iterative binary-to-BCD converter, one operand bit per cycle MSB first,
// with registered digit count and leading-zero blank mask.
module digits_serial
    import digits_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int NDIG  = 4,
    localparam int LENW  = clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] digits,
    output logic [LENW-1:0]   len,
    output logic [NDIG-1:0]   blank_mask
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [NDIG-1:0] BLANK_RST = {{(NDIG-1){1'b1}}, 1'b0};

    if (WIDTH < 4) begin : g_wchk
        $error("digits_serial: WIDTH must be at least 4");
    end
    if (NDIG < dec_digits(WIDTH)) begin : g_nchk
        $error("digits_serial: NDIG too small for WIDTH");
    end

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [4*NDIG-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [NDIG-1:0]     blank_q, blank_d;
    logic                done_q, done_d;

    logic [4*NDIG-1:0]   adj;
    logic [4*NDIG-1:0]   acc_shift;
    logic [LENW-1:0]     len_c;
    logic [NDIG-1:0]     blank_c;
    logic                unused_ovf;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_adj3 u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    // The top accumulator bit never carries for a legal NDIG.
    assign acc_shift  = {adj[4*NDIG-2:0], sh_q[WIDTH-1]};
    assign unused_ovf = adj[4*NDIG-1];

    always_comb begin
        len_c = LENW'(1);
        for (int i = 1; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] != 4'd0) begin
                len_c = LENW'(i + 1);
            end
        end
    end

    always_comb begin
        blank_c = '0;
        for (int i = 1; i < NDIG; i++) begin
            blank_c[i] = (i >= int'(len_c));
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        len_d    = len_q;
        blank_d  = blank_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                digits_d = acc_q;
                len_d    = len_c;
                blank_d  = blank_c;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            len_q    <= LENW'(1);
            blank_q  <= BLANK_RST;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            len_q    <= len_d;
            blank_q  <= blank_d;
            done_q   <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign digits     = digits_q;
    assign len        = len_q;
    assign blank_mask = blank_q;

endmodule

// File: tb/tb_digits_serial.sv
// Directed self-checking bench for digits_serial (10-bit/4-digit and
// 16-bit/5-digit instances).
module tb_digits_serial;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic [9:0]  value_a;
    logic        busy_a;
    logic        done_a;
    logic [15:0] digits_a;
    logic [2:0]  len_a;
    logic [3:0]  blank_a;

    logic        start_b;
    logic [15:0] value_b;
    logic        busy_b;
    logic        done_b;
    logic [19:0] digits_b;
    logic [2:0]  len_b;
    logic [4:0]  blank_b;

    int errors = 0;
    int checks = 0;
    logic [15:0] last_digits;

    digits_serial #(.WIDTH(10), .NDIG(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .value      (value_a),
        .busy       (busy_a),
        .done       (done_a),
        .digits     (digits_a),
        .len        (len_a),
        .blank_mask (blank_a)
    );

    digits_serial #(.WIDTH(16), .NDIG(5)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .value      (value_b),
        .busy       (busy_b),
        .done       (done_b),
        .digits     (digits_b),
        .len        (len_b),
        .blank_mask (blank_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on dut_a; returns edges seen since the current point.
    task automatic wait_done_a(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (done_a) break;
        end
    endtask

    task automatic run_a(input logic [9:0] v, input logic [15:0] ed,
                         input logic [2:0] el, input logic [3:0] eb,
                         input string tag);
        int n;
        start_a = 1'b1;
        value_a = v;
        tick();
        start_a = 1'b0;
        value_a = ~v;
        chk({tag, "_busy"}, 32'(busy_a), 32'd1);
        chk({tag, "_hold"}, 32'(digits_a), 32'(last_digits));
        wait_done_a(n);
        chk({tag, "_lat"}, 32'(n), 32'd11);
        chk({tag, "_dig"}, 32'(digits_a), 32'(ed));
        chk({tag, "_len"}, 32'(len_a), 32'(el));
        chk({tag, "_blank"}, 32'(blank_a), 32'(eb));
        chk({tag, "_busy_done"}, 32'(busy_a), 32'd0);
        last_digits = ed;
        tick();
        chk({tag, "_pulse"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        int n;
        int ndone;
        rst = 1'b1;
        start_a = 1'b0;
        value_a = '0;
        start_b = 1'b0;
        value_b = '0;
        last_digits = '0;
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_dig", 32'(digits_a), 32'd0);
        chk("rst_len", 32'(len_a), 32'd1);
        chk("rst_blank", 32'(blank_a), 32'hE);
        chk("rst_blank_b", 32'(blank_b), 32'h1E);
        tick();
        tick();
        rst = 1'b0;

        run_a(10'd1023, 16'h1023, 3'd4, 4'b0000, "v1023");
        run_a(10'd0,    16'h0000, 3'd1, 4'b1110, "v0");
        run_a(10'd10,   16'h0010, 3'd2, 4'b1100, "v10");

        // start held high: 999 then 7, value toggled mid-conversion
        start_a = 1'b1;
        value_a = 10'd999;
        tick();
        value_a = 10'd7;
        wait_done_a(n);
        chk("b2b1_lat", 32'(n), 32'd11);
        chk("b2b1_dig", 32'(digits_a), 32'h0999);
        chk("b2b1_len", 32'(len_a), 32'd3);
        tick();
        value_a = 10'd512;
        wait_done_a(n);
        chk("b2b2_gap", 32'(n + 1), 32'd12);
        chk("b2b2_dig", 32'(digits_a), 32'h0007);
        chk("b2b2_len", 32'(len_a), 32'd1);
        chk("b2b2_blank", 32'(blank_a), 32'hE);
        start_a = 1'b0;
        last_digits = 16'h0007;
        tick();

        // start pulses while busy are ignored
        start_a = 1'b1;
        value_a = 10'd321;
        tick();
        start_a = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3 || i == 6 || i == 9) begin
                start_a = 1'b1;
                value_a = 10'd100;
            end else begin
                start_a = 1'b0;
            end
            tick();
            if (done_a) begin
                ndone++;
                chk("busy_ign_dig", 32'(digits_a), 32'h0321);
                chk("busy_ign_blank", 32'(blank_a), 32'h8);
            end
        end
        start_a = 1'b0;
        chk("busy_ign_count", 32'(ndone), 32'd1);
        chk("busy_ign_len", 32'(len_a), 32'd3);

        // reset during SHIFT aborts the conversion
        start_a = 1'b1;
        value_a = 10'd512;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_dig", 32'(digits_a), 32'd0);
        chk("abort_len", 32'(len_a), 32'd1);
        chk("abort_blank", 32'(blank_a), 32'hE);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_a) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        rst = 1'b0;
        last_digits = '0;
        run_a(10'd512, 16'h0512, 3'd3, 4'b1000, "v512");

        // 16-bit / 5-digit instance
        start_b = 1'b1;
        value_b = 16'd65535;
        tick();
        start_b = 1'b0;
        value_b = 16'd0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (done_b) break;
        end
        chk("w16_lat", 32'(n), 32'd17);
        chk("w16_dig", 32'(digits_b), 32'h65535);
        chk("w16_len", 32'(len_b), 32'd5);
        chk("w16_blank", 32'(blank_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digits_serial.md
DIGITS_SERIAL -- requirements
Module: digits_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 10, binary input width (>=4).
REQ-002 SHALL have parameter NDIG, default 4, number of BCD output digits.
REQ-003 SHALL have derived localparam LENW = clog2(NDIG+1), width of len.
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port start  in  1  request conversion of value.
REQ-007 SHALL have port value  in  WIDTH  unsigned binary operand, sampled only on accept.
REQ-008 SHALL have port busy  out  1  high from accept until done cycle (exclusive).
REQ-009 SHALL have port done  out  1  one-cycle pulse, result outputs valid and updated.
REQ-010 SHALL have port digits  out  4*NDIG  BCD digits, digit 0 (units) in bits [3:0], digit i in [4i+3:4i].
REQ-011 SHALL have port len  out  LENW  significant digit count, 1..NDIG (value 0 -> 1).
REQ-012 SHALL have port blank_mask  out  NDIG  bit i high when digit i is a leading zero; bit 0 always 0.

Function
REQ-013 SHALL convert via iterative shift-and-add-3 (double dabble), one operand bit per cycle, MSB first.
REQ-014 SHALL use states IDLE, SHIFT, FINISH.
REQ-015 IDLE: start=1 at a rising edge SHALL accept, capture value, clear BCD accumulator, enter SHIFT, busy=1.
REQ-016 SHIFT: each cycle SHALL add 3 to every accumulator digit >=5, then shift left one bit, injecting next operand bit; after exactly WIDTH cycles enter FINISH.
REQ-017 FINISH: SHALL register digits, len, blank_mask from accumulator, pulse done for one cycle, return to IDLE, busy=0.
REQ-018 Latency: done SHALL be high in the cycle following edge k+WIDTH+1, where k is the accept edge.
REQ-019 start while busy=1 SHALL be ignored (no queueing, no effect on running conversion).
REQ-020 start high in the done cycle SHALL be accepted; back-to-back throughput = WIDTH+2 cycles per result.
REQ-021 value changes after accept SHALL not affect the result.
REQ-022 digits, len, blank_mask SHALL hold their last result between done pulses, including while busy.
REQ-023 len SHALL equal index of highest nonzero digit plus 1, or 1 if all digits zero.
REQ-024 blank_mask bit i (i>=1) SHALL be 1 iff i >= len.
REQ-025 Elaboration SHALL fail if NDIG is less than the decimal digit count of 2^WIDTH-1.

Reset
REQ-026 On rst asserted (asynchronous), state SHALL be IDLE, busy=0, done=0, digits=0, len=1, blank_mask={NDIG-1 ones, 0}.
REQ-027 rst during SHIFT or FINISH SHALL abort the conversion with no done pulse and outputs at reset values.
REQ-028 First start after rst deassertion SHALL be accepted at the first rising edge where rst is low.

Structure
REQ-029 Package digits_pkg SHALL hold the state enum, a constant function giving required digit count for a width, and the clog2 helper for LENW.
REQ-030 Per-digit add-3 correction SHALL be sub-module bcd_adj3 (4-bit in, 4-bit out), instantiated NDIG times.
REQ-031 len/blank_mask derivation SHALL be combinational from accumulator, registered only in FINISH.

Verification
REQ-032 WIDTH=10,NDIG=4: start with value=1023 at edge k -> done at k+11 cycle, digits=1,0,2,3 (MSB..LSB), len=4, blank_mask=0000.
REQ-033 value=0 -> digits=0000, len=1, blank_mask=1110; value=10 -> digits=0,0,1,0, len=2, blank_mask=1100.
REQ-034 start held high continuously with values 999 then 7 -> results 999 (len 3) then 7 (len 1), done pulses 12 cycles apart; value toggled mid-conversion has no effect.
REQ-035 start pulses while busy -> ignored, exactly one done per accepted start.
REQ-036 rst asserted at SHIFT cycle 5 of value=512 -> no done, outputs at reset values, next start(512) gives digits=0,5,1,2, len=3.
REQ-037 WIDTH=16,NDIG=5: value=65535 -> digits=6,5,5,3,5, len=5, done at k+17; NDIG=4 with WIDTH=16 fails elaboration.
